// File: rtl/ldpc_mem_pkg.sv
// Shared definitions for the LDPC decoder memories: clear-FSM state
// encodings and the legal read-latency range.
package ldpc_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } mem_state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic bit read_lat_legal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/msg_ram_rd_pipe.sv
// Read-data pipeline for msg_ram: LAT-deep data/valid shift register.
// Data stages load only behind a valid, so the output holds between results.
module msg_ram_rd_pipe #(
    parameter int DATA_W = 5,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    vld;
    logic [DATA_W-1:0] dat [LAT];

    // rst flushes every stage so no in-flight result survives a reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/msg_ram.sv
// Simple-dual-port LDPC message RAM with built-in clear sweep.
// Define MSG_RAM_FWD_EN for write-to-read forwarding (default: read-first).
//
// state    | meaning
// ST_CLEAR | sweeping INIT_VAL into every word, user ports ignored
// ST_IDLE  | normal read/write operation
module msg_ram
    import ldpc_mem_pkg::*;
#(
    parameter int                ADDR_W   = 3,
    parameter int                DATA_W   = 5,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              clr_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!read_lat_legal(READ_LAT)) begin : g_lat_chk
        $error("msg_ram: READ_LAT must be 1 or 2");
    end

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              wr_acc, rd_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy      = 1'b0;
        clr_done  = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (ptr == LAST_ADDR) begin
                    clr_done  = 1'b1;
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign wr_acc = wr_en && (state == ST_IDLE);
    assign rd_acc = rd_en && (state == ST_IDLE);

    // Array is deliberately not reset; the sweep defines its contents
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            mem[ptr] <= INIT_VAL;
        else if (wr_acc)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef MSG_RAM_FWD_EN
        if (wr_acc && (wr_addr == rd_addr)) rd_word = wr_data;
`endif
    end

    msg_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_msg_ram.sv
// Directed bench for msg_ram (ADDR_W=3, DATA_W=5, READ_LAT=2, INIT_VAL=5'h0A).
module tb_msg_ram;

    localparam int              L    = 2;
    localparam logic [4:0]      INIT = 5'h0A;

    logic       clk = 1'b0;
    logic       rst, clr_req, wr_en, rd_en;
    logic [2:0] wr_addr, rd_addr;
    logic [4:0] wr_data;
    logic [4:0] rd_data;
    logic       rd_valid, busy, clr_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    msg_ram #(
        .ADDR_W   (3),
        .DATA_W   (5),
        .READ_LAT (L),
        .INIT_VAL (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .clr_done (clr_done)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [4:0] wd;
        logic       re;
        logic [2:0] ra;
        logic       ev;
        logic [4:0] ed;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [4:0] wd,
                                input logic re, input logic [2:0] ra,
                                input logic ev, input logic [4:0] ed);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic idle_in();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
    endtask

    // Issue one read and check the result READ_LAT cycles later
    task automatic read_chk(input logic [2:0] a, input logic [4:0] exp, input string nm);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        idle_in();
        repeat (L - 1) @(negedge clk);
        chk({nm, "_valid"}, int'(rd_valid), 1);
        chk({nm, "_data"}, int'(rd_data), int'(exp));
    endtask

    // Sample from the current negedge (k=0) onwards over a bounded window
    task automatic watch_sweep(output int busy_n, output int cd_n, output int cd_k, output int v_n);
        busy_n = 0; cd_n = 0; cd_k = -1; v_n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_n++;
            if (clr_done) begin cd_n++; cd_k = k; end
            if (rd_valid) v_n++;
        end
    endtask

    int exp_s[8] = '{10, 10, 7, 21, 10, 31, 10, 10};

    initial begin
        int busy_n, cd_n, cd_k, v_n, got, first, last, vk;
        logic [4:0] vdata;

        rst = 1'b1;
        idle_in();
        repeat (2) @(negedge clk);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_clr_done", int'(clr_done), 0);

        // 1: initial sweep
        rst = 1'b0;
        watch_sweep(busy_n, cd_n, cd_k, v_n);
        chk("init_busy_cycles", busy_n, 8);
        chk("init_clr_done_count", cd_n, 1);
        chk("init_clr_done_pos", cd_k, 7);
        chk("init_no_valid", v_n, 0);

        // 1-3: table of single-cycle operations
        for (int i = 0; i < 8; i++) vt[i] = mk(1'b0, 3'd0, 5'd0, 1'b1, 3'(i), 1'b1, INIT);
        vt[8]  = mk(1'b1, 3'd3, 5'h15, 1'b0, 3'd0, 1'b0, INIT);
`ifdef MSG_RAM_FWD_EN
        vt[10] = mk(1'b1, 3'd5, 5'h1F, 1'b1, 3'd5, 1'b1, 5'h1F);
`else
        vt[10] = mk(1'b1, 3'd5, 5'h1F, 1'b1, 3'd5, 1'b1, 5'h0A);
`endif
        vt[9]  = mk(1'b0, 3'd0, 5'd0, 1'b1, 3'd3, 1'b1, 5'h15);
        vt[11] = mk(1'b0, 3'd0, 5'd0, 1'b1, 3'd5, 1'b1, 5'h1F);
        vt[12] = mk(1'b1, 3'd2, 5'h07, 1'b1, 3'd6, 1'b1, INIT);
        vt[13] = mk(1'b0, 3'd0, 5'd0, 1'b1, 3'd2, 1'b1, 5'h07);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_en = vt[i].re; rd_addr = vt[i].ra;
            @(negedge clk);
            idle_in();
            repeat (L - 1) @(negedge clk);
            chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(vt[i].ev));
            chk($sformatf("vec%0d_data", i), int'(rd_data), int'(vt[i].ed));
        end

        // 4: streaming reads
        got = 0; first = -1; last = -1;
        for (int k = 0; k < 8 + L + 2; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                if (got < 8) chk($sformatf("stream%0d_data", got), int'(rd_data), exp_s[got]);
                if (first < 0) first = k;
                last = k;
                got++;
            end
            idle_in();
            if (k < 8) begin rd_en = 1'b1; rd_addr = 3'(k); end
        end
        chk("stream_count", got, 8);
        chk("stream_first", first, L);
        chk("stream_contiguous", last - first + 1, 8);

        // 5: clear request with a read in the same cycle, writes and clr_req during sweep
        @(negedge clk);
        idle_in();
        clr_req = 1'b1; rd_en = 1'b1; rd_addr = 3'd3;
        busy_n = 0; cd_n = 0; cd_k = -1; v_n = 0; vk = -1; vdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (clr_done) begin cd_n++; cd_k = k; end
            if (rd_valid) begin v_n++; vk = k; vdata = rd_data; end
            idle_in();
            if (busy && !clr_done) begin
                wr_en = 1'b1; wr_addr = 3'd4; wr_data = 5'h1B;
                rd_en = 1'b1; rd_addr = 3'd0; clr_req = 1'b1;
            end
        end
        chk("clr_busy_cycles", busy_n, 8);
        chk("clr_done_count", cd_n, 1);
        chk("clr_done_pos", cd_k, 8);
        chk("clr_read_count", v_n, 1);
        chk("clr_read_pos", vk, L);
        chk("clr_read_data", int'(vdata), 5'h15);
        read_chk(3'd4, INIT, "busy_wr_ignored");
        read_chk(3'd3, INIT, "cleared_addr3");

        // 6: reset with reads in flight
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h11;
        @(negedge clk);
        idle_in();
        rd_en = 1'b1; rd_addr = 3'd0;
        @(negedge clk);
        rd_addr = 3'd1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("flush_rd_valid", int'(rd_valid), 0);
        chk("flush_rd_data", int'(rd_data), 0);
        idle_in();
        repeat (2) @(negedge clk);
        chk("hold_busy", int'(busy), 1);
        rst = 1'b0;
        watch_sweep(busy_n, cd_n, cd_k, v_n);
        chk("rst_sweep_busy", busy_n, 8);
        chk("rst_sweep_done_pos", cd_k, 7);
        chk("rst_no_stale", v_n, 0);
        read_chk(3'd0, INIT, "rst_cleared_addr0");

        // Reset in the middle of a sweep restarts it from address 0
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        idle_in();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        watch_sweep(busy_n, cd_n, cd_k, v_n);
        chk("mid_rst_busy", busy_n, 8);
        chk("mid_rst_done_pos", cd_k, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
